// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional feature macro used by reset_seq_ctrl: RSTSEQ_WDOG_EN (cycle-budget watchdog).
package rst_seq_pkg;

  localparam int unsigned SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    StSync,
    StSeq,
    StRun,
    StDone
  } rst_seq_state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Soft-reset request and per-domain reset/status bundle of the reset sequencer.
// master: the sequencer; slave: the consumer issuing sw_rst and observing status.
interface reset_seq_ctrl_if #(
  parameter int unsigned NUM_DOM = 2,
  parameter int unsigned CNT_W   = 16
) ();

  logic               sw_rst;
  logic [NUM_DOM-1:0] rst_n_out;
  logic               run;
  logic [CNT_W-1:0]   cycle_cnt;
  logic               done;

  modport master (
    input  sw_rst,
    output rst_n_out,
    output run,
    output cycle_cnt,
    output done
  );

  modport slave (
    output sw_rst,
    input  rst_n_out,
    input  run,
    input  cycle_cnt,
    input  done
  );

endinterface

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assert, synchronous deassert through Depth flops.
// rel_o flags the cycle before the synchronised reset deasserts.
module rst_sync #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no,
  output logic rel_o
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Depth-2:0], 1'b1};
    end
  end

  assign rst_no = sync_q[Depth-1];
  assign rel_o  = sync_q[Depth-2] & ~sync_q[Depth-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged release of NUM_DOM reset domains, then a run-cycle counter.
// Define RSTSEQ_WDOG_EN to stop the run phase after MAX_CYC cycles (sticky done).
module reset_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 2,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_CYC  = 79
) (
  input  logic             clk,
  input  logic             rst_n,
  reset_seq_ctrl_if.master bus
);

  localparam int unsigned HoldW = idx_width(HOLD_CYC);
  localparam int unsigned IdxW  = idx_width(NUM_DOM);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DOM - 1);

  logic           sync_rel;
  logic           unused_sync_rst_n;
  rst_seq_state_e state_q;
  logic [NUM_DOM-1:0] rst_out_q;
  logic           run_q;
  logic           done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [HoldW-1:0] hold_q;
  logic [IdxW-1:0]  idx_q;

  rst_sync #(
    .Depth (SYNC_DEPTH)
  ) u_rst_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rst_no (unused_sync_rst_n),
    .rel_o  (sync_rel)
  );

`ifdef RSTSEQ_WDOG_EN
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYC - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^CNT_W'(MAX_CYC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StSync;
      rst_out_q <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
    end else if (bus.sw_rst && (state_q != StSync)) begin
      // Soft reset outranks every other transition, including the budget expiry.
      state_q   <= StSeq;
      rst_out_q <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
    end else begin
      unique case (state_q)
        StSync: begin
          if (sync_rel) begin
            state_q <= StSeq;
          end
        end
        StSeq: begin
          if (hold_q == HoldLast) begin
            hold_q           <= '0;
            rst_out_q[idx_q] <= 1'b1;
            if (idx_q == IdxLast) begin
              state_q <= StRun;
              run_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        StRun: begin
`ifdef RSTSEQ_WDOG_EN
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end
`else
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        StDone: begin
        end
        default: begin
          state_q <= StSync;
        end
      endcase
    end
  end

  assign bus.rst_n_out = rst_out_q;
  assign bus.run       = run_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: two instances (2 domains/hold 2 and 4 domains/hold 3) against
// a model that derives outputs from the cycle count since the sequence started.
module tb_reset_seq_ctrl;

  localparam int unsigned MaxCyc = 79;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rel_edges = 0;
  int   k1 = -1;
  int   k2 = -1;

  reset_seq_ctrl_if #(.NUM_DOM(2), .CNT_W(16)) if1 ();
  reset_seq_ctrl_if #(.NUM_DOM(4), .CNT_W(16)) if2 ();

  reset_seq_ctrl #(
    .NUM_DOM  (2),
    .HOLD_CYC (2),
    .CNT_W    (16),
    .MAX_CYC  (MaxCyc)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.master)
  );

  reset_seq_ctrl #(
    .NUM_DOM  (4),
    .HOLD_CYC (3),
    .CNT_W    (16),
    .MAX_CYC  (MaxCyc)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pack(input logic [3:0] rel, input logic run, input logic done,
                                       input logic [15:0] cnt);
    return {42'd0, rel, run, done, cnt};
  endfunction

  // k = cycles since the sequence (re)started, -1 while still synchronising.
  function automatic logic [63:0] model_out(input int k, input int nd, input int hc);
    logic [3:0] rel;
    int r;
    rel = '0;
    for (int i = 0; i < nd; i++) begin
      if (k >= (i + 1) * hc) rel[i] = 1'b1;
    end
    if (k < nd * hc) return pack(rel, 1'b0, 1'b0, 16'd0);
    r = k - nd * hc;
`ifdef RSTSEQ_WDOG_EN
    if (r >= int'(MaxCyc)) return pack(rel, 1'b0, 1'b1, 16'(MaxCyc));
    return pack(rel, 1'b1, 1'b0, 16'(r));
`else
    return pack(rel, 1'b1, 1'b0, (r > 65535) ? 16'hffff : 16'(r));
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] dut1_out();
    return pack({2'b00, if1.rst_n_out}, if1.run, if1.done, if1.cycle_cnt);
  endfunction

  function automatic logic [63:0] dut2_out();
    return pack(if2.rst_n_out, if2.run, if2.done, if2.cycle_cnt);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_edges = 0;
      k1 = -1;
      k2 = -1;
    end else begin
      if (k1 >= 0) k1 = if1.sw_rst ? 0 : ((k1 < 1000000) ? k1 + 1 : k1);
      if (k2 >= 0) k2 = if2.sw_rst ? 0 : ((k2 < 1000000) ? k2 + 1 : k2);
      if (rel_edges < 2) begin
        rel_edges++;
        if (rel_edges == 2) begin
          k1 = 0;
          k2 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dut1 cycle", dut1_out(), model_out(k1, 2, 2));
    chk("dut2 cycle", dut2_out(), model_out(k2, 4, 3));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mode;
    rst_n = 1'b1;
    if1.sw_rst = 1'b0;
    if2.sw_rst = 1'b0;
    #1 rst_n = 1'b0;
    #49;
    chk("reset dut1", dut1_out(), 64'd0);
    chk("reset dut2", dut2_out(), 64'd0);
    #50 rst_n = 1'b1;

    // Power-on release timeline and budget.
    for (int e = 1; e <= 90; e++) begin
      step();
      if (e == 3) chk("pwr e3 dut1", dut1_out(), pack(4'b0000, 1'b0, 1'b0, 16'd0));
      if (e == 4) chk("pwr e4 dut1", dut1_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));
      if (e == 5) chk("pwr e5 dut2", dut2_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));
      if (e == 6) chk("pwr e6 dut1", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd0));
      if (e == 8) chk("pwr e8 dut2", dut2_out(), pack(4'b0011, 1'b0, 1'b0, 16'd0));
      if (e == 11) chk("pwr e11 dut2", dut2_out(), pack(4'b0111, 1'b0, 1'b0, 16'd0));
      if (e == 14) chk("pwr e14 dut2", dut2_out(), pack(4'b1111, 1'b1, 1'b0, 16'd0));
      if (e == 84) chk("budget e84", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd78));
`ifdef RSTSEQ_WDOG_EN
      if (e == 85) chk("budget e85", dut1_out(), pack(4'b0011, 1'b0, 1'b1, 16'd79));
      if (e == 90) chk("budget hold", dut1_out(), pack(4'b0011, 1'b0, 1'b1, 16'd79));
`else
      if (e == 85) chk("nowdog e85", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd79));
`endif
    end

    // Soft reset, then again mid-sequence after domain 0 is out.
    if1.sw_rst = 1'b1;
    step();
    chk("swrst clear", dut1_out(), 64'd0);
    if1.sw_rst = 1'b0;
    step();
    step();
    chk("swrst rel0", dut1_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));
    if1.sw_rst = 1'b1;
    step();
    chk("midseq clear", dut1_out(), 64'd0);
    if1.sw_rst = 1'b0;
    step();
    step();
    chk("midseq rel0", dut1_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));
    step();
    step();
    chk("midseq run", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd0));

    // Soft reset colliding with the last budget cycle.
    repeat (78) step();
    chk("collide pre", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd78));
    if1.sw_rst = 1'b1;
    step();
    chk("collide", dut1_out(), 64'd0);
    if1.sw_rst = 1'b0;
    step();
    step();
    chk("collide seq", dut1_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));

    // Asynchronous reset in the middle of the run phase.
    repeat (4) step();
    chk("async pre", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd2));
    #2 rst_n = 1'b0;
    #1;
    chk("async dut1", dut1_out(), 64'd0);
    chk("async dut2", dut2_out(), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("reseq rel0", dut1_out(), pack(4'b0001, 1'b0, 1'b0, 16'd0));
    repeat (2) step();
    chk("reseq run", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'd0));

    // Random soft resets and occasional hard resets; quiet blocks let budgets expire.
    for (int b = 0; b < 15; b++) begin
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < 200; c++) begin
        step();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        if1.sw_rst = (mode == 1) ? ($urandom_range(0, 7) == 0) :
                     (mode == 2) ? ($urandom_range(0, 59) == 0) : 1'b0;
        if2.sw_rst = (mode == 1) ? ($urandom_range(0, 7) == 0) :
                     (mode == 2) ? ($urandom_range(0, 59) == 0) : 1'b0;
      end
    end
    if1.sw_rst = 1'b0;
    if2.sw_rst = 1'b0;

    // Long undisturbed run to reach counter saturation.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (65560) step();
`ifdef RSTSEQ_WDOG_EN
    chk("long dut1", dut1_out(), pack(4'b0011, 1'b0, 1'b1, 16'd79));
    chk("long dut2", dut2_out(), pack(4'b1111, 1'b0, 1'b1, 16'd79));
`else
    chk("sat dut1", dut1_out(), pack(4'b0011, 1'b1, 1'b0, 16'hffff));
    chk("sat dut2", dut2_out(), pack(4'b1111, 1'b1, 1'b0, 16'hffff));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOM, default 2: number of downstream reset domains (>=1).
REQ-002 SHALL have parameter HOLD_CYC, default 2: clk cycles between successive domain releases (>=1).
REQ-003 SHALL have parameter CNT_W, default 16: width of cycle_cnt.
REQ-004 SHALL have parameter MAX_CYC, default 79: run-cycle budget (1 <= MAX_CYC < 2**CNT_W).
REQ-005 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port sw_rst  input  1: synchronous soft-reset request; restarts the sequence.
REQ-008 SHALL have port rst_n_out  output  NUM_DOM: per-domain active-low resets.
REQ-009 SHALL have port run  output  1: high while all domains are released and the budget is not exhausted.
REQ-010 SHALL have port cycle_cnt  output  CNT_W: run cycles elapsed.
REQ-011 SHALL have port done  output  1: sticky budget-exhausted flag.

Function
REQ-012 SHALL implement FSM states SYNC, SEQ, RUN, DONE.
REQ-013 SHALL pass rst_n through a 2-flop synchroniser; SYNC->SEQ on the edge where the synchronised reset goes high (2nd rising edge after rst_n deasserts).
REQ-014 SHALL, in SEQ, release rst_n_out[i] exactly (i+1)*HOLD_CYC cycles after entering SEQ, index 0 first, one domain per HOLD_CYC interval.
REQ-015 SHALL go SEQ->RUN on the edge releasing rst_n_out[NUM_DOM-1]; cycle_cnt=0 at that edge.
REQ-016 SHALL increment cycle_cnt by 1 per cycle in RUN; RUN->DONE on the edge where cycle_cnt would reach MAX_CYC; cycle_cnt then holds MAX_CYC.
REQ-017 SHALL, in DONE, hold done=1, run=0, rst_n_out all 1s until reset or sw_rst.
REQ-018 SHALL, on sw_rst=1 in SEQ/RUN/DONE, drive all rst_n_out to 0, clear cycle_cnt, done, hold counter and domain index at the next edge, and re-enter SEQ.
REQ-019 SHALL give sw_rst priority over every other transition in the same cycle (including RUN->DONE).
REQ-020 SHALL ignore sw_rst in SYNC.
REQ-021 SHALL keep rst_n_out monotonic within a sequence: a released domain only re-asserts via sw_rst or rst_n.

Reset
REQ-022 SHALL, on rst_n=0, immediately (asynchronously) drive rst_n_out=0, run=0, done=0, cycle_cnt=0, state=SYNC, synchroniser flops=0.
REQ-023 SHALL, on rst_n assertion mid-sequence or mid-run, abandon all progress; no partial state survives.

Configuration
REQ-024 SHALL use macro RSTSEQ_WDOG_EN for the cycle-budget watchdog.
REQ-025 SHALL, with RSTSEQ_WDOG_EN defined, behave per REQ-016/017.
REQ-026 SHALL, without RSTSEQ_WDOG_EN, never enter DONE: done tied 0, cycle_cnt saturates at 2**CNT_W-1, run stays 1 after SEQ.

Structure
REQ-027 SHALL place the FSM state typedef and SYNC_DEPTH=2 constant in shared package rst_seq_pkg.
REQ-028 SHALL instantiate sub-module rst_sync (async-assert, sync-deassert, SYNC_DEPTH flops) for the rst_n synchroniser.

Verification
REQ-029 SHALL cover power-on: 100 MHz clk, rst_n low 0-100 ns then high, defaults -> rst_n_out[0] high at 4th rising edge after release, rst_n_out[1] at 6th, run high with it.
REQ-030 SHALL cover budget: defaults, WDOG on -> done=1, run=0, cycle_cnt=79 exactly 79 cycles after run rises; stays until reset.
REQ-031 SHALL cover sw_rst mid-SEQ: pulse after rst_n_out[0] release -> both outputs 0 next edge, rst_n_out[0] re-released 2 cycles later.
REQ-032 SHALL cover collision: sw_rst asserted on the cycle cycle_cnt=78 -> done stays 0, cycle_cnt=0, state SEQ.
REQ-033 SHALL cover async reset mid-RUN: rst_n low between edges -> all outputs 0 before next edge; full resequence on release.
REQ-034 SHALL cover NUM_DOM=4, HOLD_CYC=3, WDOG off -> releases at 3/6/9/12 cycles into SEQ, done never asserts, cycle_cnt saturates at 65535.
